// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key channel selector
// Holds the per-key event FSM state encoding and the synchroniser depth.
package key_pkg;

    localparam int KEY_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        KEY_IDLE   = 2'd0,
        KEY_HOLD   = 2'd1,
        KEY_REPEAT = 2'd2
    } key_state_e;

endpackage

// File: rtl/key_channel_select_if.sv
// rtl/key_channel_select_if.sv - key/channel bundle between buttons, enable mask and read mux
// Ports:
//   key_next, key_prev : raw asynchronous buttons
//   ch_enable          : per-channel enable mask
//   ch_sel             : selected read channel
//   ch_changed         : one-cycle pulse on a new ch_sel
//   key_held           : {prev, next} debounced pressed level
interface key_channel_select_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              key_next;
    logic              key_prev;
    logic [NUM_CH-1:0] ch_enable;
    logic [CH_W-1:0]   ch_sel;
    logic              ch_changed;
    logic [1:0]        key_held;

    modport slave (
        input  key_next,
        input  key_prev,
        input  ch_enable,
        output ch_sel,
        output ch_changed,
        output key_held
    );

    modport master (
        output key_next,
        output key_prev,
        output ch_enable,
        input  ch_sel,
        input  ch_changed,
        input  key_held
    );

endinterface

// File: rtl/key_press_event.sv
// rtl/key_press_event.sv - synchroniser, debouncer and press/auto-repeat event FSM for one key
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   key_raw   : raw asynchronous button input
//   level     : debounced pressed level (registered)
//   evt       : one-cycle event pulse (press and auto-repeat)
module key_press_event
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 2_000_000,
    parameter int LONG_PRESS_CYC = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int KEY_ACT_LOW    = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_raw,
    output logic level,
    output logic evt
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TM_MAX = (LONG_PRESS_CYC > REPEAT_CYC) ? LONG_PRESS_CYC : REPEAT_CYC;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    logic [KEY_SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]            db_cnt;
    logic [TM_W-1:0]            tmr;
    key_state_e                 state;

    logic key_norm;
    logic key_s;
    logic db_flip;
    logic rise;

    // Normalise before the synchroniser so its reset value means "released".
    assign key_norm = (KEY_ACT_LOW != 0) ? ~key_raw : key_raw;
    assign key_s    = sync_q[KEY_SYNC_STAGES-1];

    // Flip on the DEBOUNCE_CYC-th consecutive differing sample; the press
    // event is raised from the same condition so it lands with the level.
    assign db_flip = (key_s != level) && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
    assign rise    = db_flip && !level;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[KEY_SYNC_STAGES-2:0], key_norm};
            if (key_s == level) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= KEY_IDLE;
            tmr   <= '0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            case (state)
                KEY_IDLE: begin
                    tmr <= '0;
                    if (rise) begin
                        evt   <= 1'b1;
                        state <= KEY_HOLD;
                    end
                end
                KEY_HOLD: begin
                    if (!level) begin
                        state <= KEY_IDLE;
                        tmr   <= '0;
                    end else if (tmr == TM_W'(LONG_PRESS_CYC - 1)) begin
                        // With auto-repeat off the timer parks here until release.
                        if (REPEAT_CYC != 0) begin
                            evt   <= 1'b1;
                            state <= KEY_REPEAT;
                            tmr   <= '0;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                KEY_REPEAT: begin
                    if (!level) begin
                        state <= KEY_IDLE;
                        tmr   <= '0;
                    end else if (tmr == TM_W'(REPEAT_CYC - 1)) begin
                        evt <= 1'b1;
                        tmr <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    state <= KEY_IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_channel_select.sv
// rtl/key_channel_select.sv - two-key debounced read-channel selector with skip, wrap/saturate and auto-repeat
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : key_channel_select_if.slave (keys, enable mask in; ch_sel, ch_changed, key_held out)
module key_channel_select
    import key_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int RESET_CH       = 0,
    parameter int DEBOUNCE_CYC   = 2_000_000,
    parameter int LONG_PRESS_CYC = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int WRAP           = 1,
    parameter int KEY_ACT_LOW    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    key_channel_select_if.slave   bus
);
    localparam int CH_W = $clog2(NUM_CH);

    logic            lvl_next, lvl_prev;
    logic            ev_next, ev_prev;
    logic [CH_W-1:0] ch_sel_q;
    logic            ch_changed_q;
    logic [CH_W-1:0] target;
    logic            found;
    logic            wrapped;
    int              cand;

    key_press_event #(
        .DEBOUNCE_CYC   (DEBOUNCE_CYC),
        .LONG_PRESS_CYC (LONG_PRESS_CYC),
        .REPEAT_CYC     (REPEAT_CYC),
        .KEY_ACT_LOW    (KEY_ACT_LOW)
    ) u_next (
        .clk     (clk),
        .rstn    (rstn),
        .key_raw (bus.key_next),
        .level   (lvl_next),
        .evt     (ev_next)
    );

    key_press_event #(
        .DEBOUNCE_CYC   (DEBOUNCE_CYC),
        .LONG_PRESS_CYC (LONG_PRESS_CYC),
        .REPEAT_CYC     (REPEAT_CYC),
        .KEY_ACT_LOW    (KEY_ACT_LOW)
    ) u_prev (
        .clk     (clk),
        .rstn    (rstn),
        .key_raw (bus.key_prev),
        .level   (lvl_prev),
        .evt     (ev_prev)
    );

    // Nearest enabled channel in the step direction, excluding the current
    // one; simultaneous next/prev events cancel. No hit leaves target as is.
    always_comb begin
        target  = ch_sel_q;
        found   = 1'b0;
        wrapped = 1'b0;
        cand    = 0;
        if (ev_next ^ ev_prev) begin
            for (int i = 1; i < NUM_CH; i++) begin
                cand    = ev_next ? (int'(ch_sel_q) + i) : (int'(ch_sel_q) - i);
                wrapped = (cand >= NUM_CH) || (cand < 0);
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end else if (cand < 0) begin
                    cand = cand + NUM_CH;
                end
                if (!found && bus.ch_enable[CH_W'(cand)] && ((WRAP != 0) || !wrapped)) begin
                    target = CH_W'(cand);
                    found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_sel_q     <= CH_W'(RESET_CH);
            ch_changed_q <= 1'b0;
        end else begin
            ch_sel_q     <= target;
            ch_changed_q <= (target != ch_sel_q);
        end
    end

    assign bus.ch_sel     = ch_sel_q;
    assign bus.ch_changed = ch_changed_q;
    assign bus.key_held   = {lvl_prev, lvl_next};

endmodule

// File: tb/tb_key_channel_select.sv
// tb/tb_key_channel_select.sv - directed bench for key_channel_select, wrap and saturate instances
module tb_key_channel_select;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   chg_w = 0;
    int   chg_s = 0;

    always #5 clk = ~clk;

    key_channel_select_if #(.NUM_CH(4)) bw ();
    key_channel_select_if #(.NUM_CH(4)) bs ();

    key_channel_select #(
        .NUM_CH(4), .RESET_CH(0), .DEBOUNCE_CYC(4), .LONG_PRESS_CYC(20),
        .REPEAT_CYC(5), .WRAP(1), .KEY_ACT_LOW(1)
    ) dut_w (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bw)
    );

    key_channel_select #(
        .NUM_CH(4), .RESET_CH(0), .DEBOUNCE_CYC(4), .LONG_PRESS_CYC(20),
        .REPEAT_CYC(5), .WRAP(0), .KEY_ACT_LOW(1)
    ) dut_s (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bs)
    );

    always @(negedge clk) begin
        if (bw.ch_changed === 1'b1) chg_w++;
        if (bs.ch_changed === 1'b1) chg_s++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic nx, input logic pv);
        bw.key_next = ~nx;
        bw.key_prev = ~pv;
        bs.key_next = ~nx;
        bs.key_prev = ~pv;
    endtask

    task automatic set_enable(input logic [3:0] en);
        bw.ch_enable = en;
        bs.ch_enable = en;
    endtask

    // which: 0 = next, 1 = prev, 2 = both together
    task automatic tap(input int which);
        set_keys(which != 1, which != 0);
        step(10);
        set_keys(1'b0, 1'b0);
        step(10);
    endtask

    task automatic test_reset();
        set_keys(1'b0, 1'b0);
        set_enable(4'b1111);
        rstn = 1'b0;
        step(3);
        total++; if (bw.ch_sel !== 2'd0) begin bad++; $display("FAIL reset_sel_w: got %0d exp 0", bw.ch_sel); end
        total++; if (bs.ch_sel !== 2'd0) begin bad++; $display("FAIL reset_sel_s: got %0d exp 0", bs.ch_sel); end
        total++; if (bw.ch_changed !== 1'b0) begin bad++; $display("FAIL reset_chg: got %b exp 0", bw.ch_changed); end
        total++; if (bw.key_held !== 2'b00) begin bad++; $display("FAIL reset_held: got %b exp 00", bw.key_held); end
        rstn = 1'b1;
        step(2);
    endtask

    task automatic test_clean_press();
        set_keys(1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k == 5) begin
                total++; if (bw.key_held !== 2'b00) begin bad++; $display("FAIL press_held_k5: got %b exp 00", bw.key_held); end
            end
            if (k == 6) begin
                total++; if (bw.key_held !== 2'b01) begin bad++; $display("FAIL press_held_k6: got %b exp 01", bw.key_held); end
                total++; if (bw.ch_sel !== 2'd0) begin bad++; $display("FAIL press_sel_k6: got %0d exp 0", bw.ch_sel); end
            end
            if (k == 7) begin
                total++; if (bw.ch_sel !== 2'd1) begin bad++; $display("FAIL press_sel_k7: got %0d exp 1", bw.ch_sel); end
                total++; if (bw.ch_changed !== 1'b1) begin bad++; $display("FAIL press_chg_k7: got %b exp 1", bw.ch_changed); end
                total++; if (bs.ch_sel !== 2'd1) begin bad++; $display("FAIL press_sel_s_k7: got %0d exp 1", bs.ch_sel); end
            end
            if (k == 8) begin
                total++; if (bw.ch_changed !== 1'b0) begin bad++; $display("FAIL press_chg_k8: got %b exp 0", bw.ch_changed); end
            end
        end
        set_keys(1'b0, 1'b0);
        step(10);
        total++; if (bw.key_held !== 2'b00) begin bad++; $display("FAIL release_held: got %b exp 00", bw.key_held); end
    endtask

    task automatic test_bounce();
        int c0;
        c0 = chg_w;
        set_keys(1'b1, 1'b0);
        step(3);
        set_keys(1'b0, 1'b0);
        step(12);
        total++; if (bw.ch_sel !== 2'd1) begin bad++; $display("FAIL bounce_sel: got %0d exp 1", bw.ch_sel); end
        total++; if (chg_w !== c0) begin bad++; $display("FAIL bounce_pulses: got %0d exp %0d", chg_w, c0); end
    endtask

    task automatic test_wrap();
        int cs;
        tap(0);
        tap(0);
        total++; if (bw.ch_sel !== 2'd3 || bs.ch_sel !== 2'd3) begin bad++; $display("FAIL wrap_pre: got %0d/%0d exp 3/3", bw.ch_sel, bs.ch_sel); end
        cs = chg_s;
        tap(0);
        total++; if (bw.ch_sel !== 2'd0) begin bad++; $display("FAIL wrap_next_w: got %0d exp 0", bw.ch_sel); end
        total++; if (bs.ch_sel !== 2'd3) begin bad++; $display("FAIL sat_next_s: got %0d exp 3", bs.ch_sel); end
        total++; if (chg_s !== cs) begin bad++; $display("FAIL sat_next_pulse: got %0d exp %0d", chg_s, cs); end
        tap(1);
        tap(1);
        tap(1);
        total++; if (bw.ch_sel !== 2'd1 || bs.ch_sel !== 2'd0) begin bad++; $display("FAIL prev_x3: got %0d/%0d exp 1/0", bw.ch_sel, bs.ch_sel); end
        cs = chg_s;
        tap(1);
        total++; if (bw.ch_sel !== 2'd0) begin bad++; $display("FAIL wrap_prev_w: got %0d exp 0", bw.ch_sel); end
        total++; if (bs.ch_sel !== 2'd0 || chg_s !== cs) begin bad++; $display("FAIL sat_prev_s: got sel %0d pulses %0d exp sel 0 pulses %0d", bs.ch_sel, chg_s, cs); end
    endtask

    task automatic test_skip();
        int cw, cs;
        set_enable(4'b1010);
        tap(0);
        total++; if (bw.ch_sel !== 2'd1 || bs.ch_sel !== 2'd1) begin bad++; $display("FAIL skip_1: got %0d/%0d exp 1/1", bw.ch_sel, bs.ch_sel); end
        tap(0);
        total++; if (bw.ch_sel !== 2'd3 || bs.ch_sel !== 2'd3) begin bad++; $display("FAIL skip_3: got %0d/%0d exp 3/3", bw.ch_sel, bs.ch_sel); end
        tap(0);
        total++; if (bw.ch_sel !== 2'd1 || bs.ch_sel !== 2'd3) begin bad++; $display("FAIL skip_wrap: got %0d/%0d exp 1/3", bw.ch_sel, bs.ch_sel); end
        set_enable(4'b0000);
        cw = chg_w; cs = chg_s;
        tap(0);
        total++; if (bw.ch_sel !== 2'd1 || bs.ch_sel !== 2'd3) begin bad++; $display("FAIL none_en_sel: got %0d/%0d exp 1/3", bw.ch_sel, bs.ch_sel); end
        total++; if (chg_w !== cw || chg_s !== cs) begin bad++; $display("FAIL none_en_pulse: got %0d/%0d exp %0d/%0d", chg_w, chg_s, cw, cs); end
        set_enable(4'b0010);
        cw = chg_w;
        tap(1);
        total++; if (bw.ch_sel !== 2'd1 || chg_w !== cw) begin bad++; $display("FAIL only_cur: got sel %0d pulses %0d exp sel 1 pulses %0d", bw.ch_sel, chg_w, cw); end
        total++; if (bs.ch_sel !== 2'd1) begin bad++; $display("FAIL cur_disabled: got %0d exp 1", bs.ch_sel); end
        set_enable(4'b1111);
    endtask

    task automatic test_repeat();
        logic [1:0] ew, es;
        logic       cw_exp, cs_exp;
        tap(1);
        total++; if (bw.ch_sel !== 2'd0 || bs.ch_sel !== 2'd0) begin bad++; $display("FAIL rep_pre: got %0d/%0d exp 0/0", bw.ch_sel, bs.ch_sel); end
        set_keys(1'b1, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            step(1);
            ew = (k < 7) ? 2'd0 : (k < 27) ? 2'd1 : (k < 32) ? 2'd2 : (k < 37) ? 2'd3 : (k < 42) ? 2'd0 : 2'd1;
            es = (k < 7) ? 2'd0 : (k < 27) ? 2'd1 : (k < 32) ? 2'd2 : 2'd3;
            cw_exp = (k == 7) || (k == 27) || (k == 32) || (k == 37) || (k == 42);
            cs_exp = (k == 7) || (k == 27) || (k == 32);
            total++; if (bw.ch_sel !== ew || bw.ch_changed !== cw_exp) begin bad++; $display("FAIL rep_w k=%0d: got sel %0d chg %b exp sel %0d chg %b", k, bw.ch_sel, bw.ch_changed, ew, cw_exp); end
            total++; if (bs.ch_sel !== es || bs.ch_changed !== cs_exp) begin bad++; $display("FAIL rep_s k=%0d: got sel %0d chg %b exp sel %0d chg %b", k, bs.ch_sel, bs.ch_changed, es, cs_exp); end
            if (k == 36) set_keys(1'b0, 1'b0);
        end
        step(10);
        total++; if (bw.ch_sel !== 2'd1 || bs.ch_sel !== 2'd3) begin bad++; $display("FAIL rep_post: got %0d/%0d exp 1/3", bw.ch_sel, bs.ch_sel); end
    endtask

    task automatic test_simultaneous();
        int cw, cs;
        cw = chg_w; cs = chg_s;
        set_keys(1'b1, 1'b1);
        step(10);
        total++; if (bw.key_held !== 2'b11) begin bad++; $display("FAIL both_held: got %b exp 11", bw.key_held); end
        set_keys(1'b0, 1'b0);
        step(10);
        total++; if (bw.ch_sel !== 2'd1 || bs.ch_sel !== 2'd3) begin bad++; $display("FAIL both_sel: got %0d/%0d exp 1/3", bw.ch_sel, bs.ch_sel); end
        total++; if (chg_w !== cw || chg_s !== cs) begin bad++; $display("FAIL both_pulse: got %0d/%0d exp %0d/%0d", chg_w, chg_s, cw, cs); end
    endtask

    task automatic test_reset_mid_repeat();
        logic [1:0] e;
        set_keys(1'b1, 1'b0);
        step(30);
        total++; if (bw.ch_sel !== 2'd3) begin bad++; $display("FAIL rst_pre: got %0d exp 3", bw.ch_sel); end
        rstn = 1'b0;
        #1;
        total++; if (bw.ch_sel !== 2'd0 || bs.ch_sel !== 2'd0) begin bad++; $display("FAIL rst_async_sel: got %0d/%0d exp 0/0", bw.ch_sel, bs.ch_sel); end
        total++; if (bw.key_held !== 2'b00) begin bad++; $display("FAIL rst_async_held: got %b exp 00", bw.key_held); end
        step(2);
        rstn = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            step(1);
            e = (k < 7) ? 2'd0 : 2'd1;
            total++; if (bw.ch_sel !== e || bw.ch_changed !== (k == 7)) begin bad++; $display("FAIL rst_rep k=%0d: got sel %0d chg %b exp sel %0d chg %b", k, bw.ch_sel, bw.ch_changed, e, (k == 7)); end
            if (k == 6) begin
                total++; if (bs.ch_sel !== 2'd0 || bw.key_held !== 2'b01) begin bad++; $display("FAIL rst_k6: got sel %0d held %b exp sel 0 held 01", bs.ch_sel, bw.key_held); end
            end
        end
        set_keys(1'b0, 1'b0);
        step(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_skip();
        test_repeat();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
